// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin req/ack arbiter sharing one 32x8 synchronous memory between two ports
module mem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   output logic              mem_memRead,
   output logic              mem_memWrite,
   input  logic [DATA_W-1:0] mem_out,
   output logic              busy,
   output logic              grant
);
   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
   state_t state;
   logic last_grant, op_we, win, win_we;
   // winner: a lone requester wins, a tie goes to the port not served last
   always_comb begin
      win = (req0 & req1) ? ~last_grant : req1;
      win_we = win ? we1 : we0;
   end
   // arbitration FSM with registered memory controls, acks and read data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         last_grant <= 1'b1;
         op_we <= 1'b0;
         grant <= 1'b0;
         busy <= 1'b0;
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         rdata0 <= '0;
         rdata1 <= '0;
         mem_address <= '0;
         mem_writeData <= '0;
         mem_memRead <= 1'b0;
         mem_memWrite <= 1'b0;
      end else begin
         case (state)
            IDLE: if (req0 | req1) begin
               state <= ACCESS;
               busy <= 1'b1;
               grant <= win;
               last_grant <= win;
               op_we <= win_we;
               mem_address <= win ? addr1 : addr0;
               mem_writeData <= win ? wdata1 : wdata0;
               mem_memRead <= ~win_we;
               mem_memWrite <= win_we;
            end
            ACCESS: begin
               state <= CAPTURE;
               mem_memRead <= 1'b0;
               mem_memWrite <= 1'b0;
            end
            CAPTURE: begin
               state <= RESP;
               ack0 <= ~grant;
               ack1 <= grant;
               if (!op_we && !grant) rdata0 <= mem_out;
               if (!op_we && grant) rdata1 <= mem_out;
            end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
               ack0 <= 1'b0;
               ack1 <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a behavioural 32x8 memory
module tb_mem_arbiter;
   logic clk, rst, req0, req1, we0, we1, ack0, ack1, mem_memRead, mem_memWrite, busy, grant;
   logic [4:0] addr0, addr1, mem_address;
   logic [7:0] wdata0, wdata1, rdata0, rdata1, mem_writeData, mem_out;
   logic [7:0] mem [32];
   logic mem_rst;
   int n_chk = 0;
   int n_fail = 0;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_address(mem_address), .mem_writeData(mem_writeData),
      .mem_memRead(mem_memRead), .mem_memWrite(mem_memWrite),
      .mem_out(mem_out), .busy(busy), .grant(grant)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // memory with active-high reset and registered output; reset restores the preloaded words
   assign mem_rst = ~rst;
   always @(posedge clk or posedge mem_rst) begin
      if (mem_rst) begin
         mem_out <= 8'h00;
         mem[27] <= 8'h66;
         mem[28] <= 8'hAA;
      end else begin
         if (mem_memWrite) mem[mem_address] <= mem_writeData;
         if (mem_memRead) mem_out <= mem[mem_address];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // per-cycle invariants
   always @(negedge clk) begin
      if (rst) begin
         chk("rd_wr_exclusive", 64'(mem_memRead & mem_memWrite), 64'd0);
         chk("ack_exclusive", 64'(ack0 & ack1), 64'd0);
      end
   end

   // one full transaction on port p with checks at every edge
   task automatic do_op(input logic p, input logic w, input logic [4:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
      if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
      else begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
      tick();
      chk("op_grant", 64'(grant), 64'(p));
      chk("op_busy", 64'(busy), 64'd1);
      chk("op_rd", 64'(mem_memRead), 64'(!w));
      chk("op_wr", 64'(mem_memWrite), 64'(w));
      chk("op_addr", 64'(mem_address), 64'(a));
      if (w) chk("op_wdata", 64'(mem_writeData), 64'(d));
      tick();
      chk("op_pulse_end", 64'({mem_memRead, mem_memWrite}), 64'd0);
      chk("op_no_early_ack", 64'({ack0, ack1}), 64'd0);
      tick();
      chk("op_ack", 64'({ack0, ack1}), p ? 64'b01 : 64'b10);
      chk("op_rdata", 64'(p ? rdata1 : rdata0), 64'(exp_rd));
      req0 = 0;
      req1 = 0;
      tick();
      chk("op_ack_end", 64'({ack0, ack1}), 64'd0);
      chk("op_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      logic exp_g;
      rst = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      #1;
      chk("reset_outputs",
          {ack0, ack1, busy, grant, mem_memRead, mem_memWrite, mem_address, mem_writeData, rdata0, rdata1},
          64'd0);
      tick();
      tick();
      rst = 1;
      // start a read, then pull reset while in ACCESS
      req0 = 1; addr0 = 27;
      tick();
      chk("pre_reset_busy", 64'(busy), 64'd1);
      chk("pre_reset_rd", 64'(mem_memRead), 64'd1);
      chk("pre_reset_addr", 64'(mem_address), 64'd27);
      #2 rst = 0;
      #1;
      chk("async_reset_outputs",
          {ack0, ack1, busy, grant, mem_memRead, mem_memWrite, mem_address, mem_writeData, rdata0, rdata1},
          64'd0);
      req1 = 1; addr1 = 28;
      #2 rst = 1;
      // both request after reset: port 0 must win first, then port 1
      tick();
      chk("first_grant", 64'(grant), 64'd0);
      chk("first_rd", 64'(mem_memRead), 64'd1);
      chk("first_addr", 64'(mem_address), 64'd27);
      tick();
      chk("first_rd_end", 64'(mem_memRead), 64'd0);
      chk("first_busy", 64'(busy), 64'd1);
      tick();
      chk("read27_ack", 64'({ack0, ack1}), 64'b10);
      chk("read27_rdata0", 64'(rdata0), 64'h66);
      chk("read27_rdata1", 64'(rdata1), 64'h00);
      req0 = 0;
      tick();
      chk("read27_ack_end", 64'(ack0), 64'd0);
      chk("read27_idle", 64'(busy), 64'd0);
      tick();
      chk("second_grant", 64'(grant), 64'd1);
      chk("second_addr", 64'(mem_address), 64'd28);
      req1 = 0;
      tick();
      tick();
      chk("read28_ack", 64'({ack0, ack1}), 64'b01);
      chk("read28_rdata1", 64'(rdata1), 64'hAA);
      chk("read28_rdata0_kept", 64'(rdata0), 64'h66);
      tick();
      chk("read28_ack_end", 64'(ack1), 64'd0);
      // write then read through the other port
      do_op(1, 1, 31, 8'hBB, 8'hAA);
      chk("write_keeps_rdata0", 64'(rdata0), 64'h66);
      do_op(0, 0, 31, 8'h00, 8'hBB);
      // read then write: rdata0 must hold across the write
      do_op(0, 0, 28, 8'h00, 8'hAA);
      do_op(0, 1, 5, 8'h01, 8'hAA);
      do_op(0, 0, 5, 8'h00, 8'h01);
      // contention: last grant was port 0, so port 1 goes first, then alternating
      req0 = 1; we0 = 0; addr0 = 27;
      req1 = 1; we1 = 0; addr1 = 28;
      exp_g = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("cont_grant", 64'(grant), 64'(exp_g));
         tick();
         tick();
         chk("cont_ack", 64'({ack0, ack1}), exp_g ? 64'b01 : 64'b10);
         tick();
         chk("cont_ack_end", 64'({ack0, ack1}), 64'd0);
         exp_g = ~exp_g;
      end
      req0 = 0;
      req1 = 0;
      tick();
      chk("final_idle", 64'(busy), 64'd0);
      chk("final_rdata", 64'({rdata0, rdata1}), 64'h66AA);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
